// File: rtl/multi_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multi_adder_pkg
//  Brief    : FSM state encoding and helper function for multi_operand_adder.
//  Revision : 1.0
// ============================================================================
package multi_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to index n entries (0..n-1); callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_rise.sv
`default_nettype none
// ============================================================================
//  Module   : edge_rise
//  Brief    : N-bit registered rising-edge detector (rise = x & ~x_q).
//  Revision : 1.0
// ============================================================================
module edge_rise #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] x,
    output logic [N-1:0] rise
);

    logic [N-1:0] r_x_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x_q <= '0;
        end else begin
            r_x_q <= x;
        end
    end

    assign rise = x & ~r_x_q;

endmodule
`default_nettype wire

// File: rtl/multi_operand_adder.sv
`default_nettype none
// ============================================================================
//  Module   : multi_operand_adder
//  Brief    : Sequential multi-operand adder, one operand per clock, sticky carry.
//  Revision : 1.0
// ============================================================================
module multi_operand_adder
    import multi_adder_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NUM_OPS = 5,
    parameter int SUM_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_OPS-1:0] load,
    input  logic [WIDTH-1:0]   din,
    input  logic               start,
    input  logic               auto_i,
    input  logic               clr,
    output logic [SUM_W-1:0]   sum,
    output logic               cout,
    output logic               busy,
    output logic               done
);

    localparam int                 c_idx_w    = clog2(NUM_OPS);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_OPS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    if (SUM_W < WIDTH) begin : g_bad_sum_w
        $error("multi_operand_adder: SUM_W must be >= WIDTH");
    end
    if (NUM_OPS < 2) begin : g_bad_num_ops
        $error("multi_operand_adder: NUM_OPS must be >= 2");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_op [NUM_OPS];
    logic [SUM_W-1:0]     r_acc;
    logic                 r_flag;
    logic [c_idx_w-1:0]   r_idx;
    logic [SUM_W-1:0]     r_sum;
    logic                 r_cout;
    logic [NUM_OPS-1:0]   w_load_rise;
    logic                 w_start_rise;
    logic [SUM_W:0]       w_add;
    logic                 w_flag_next;
    logic                 w_last;

    edge_rise #(.N(NUM_OPS)) u_load_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (load),
        .rise (w_load_rise)
    );

    edge_rise #(.N(1)) u_start_edge (
        .clk  (clk),
        .rst_n(rst_n),
        .x    (start),
        .rise (w_start_rise)
    );

    // Extra MSB of w_add is the carry out of this single add.
    assign w_add       = {1'b0, r_acc} + {{(SUM_W + 1 - WIDTH){1'b0}}, r_op[r_idx]};
    assign w_flag_next = r_flag | w_add[SUM_W];
    assign w_last      = (r_idx == c_idx_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_start_rise) w_state_next = ST_ACC;
            ST_ACC:  if (w_last)       w_state_next = ST_DONE;
            ST_DONE: w_state_next = auto_i ? ST_ACC : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                r_op[i] <= '0;
            end
            r_acc  <= '0;
            r_flag <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Clear takes priority over any simultaneous load rise.
                    if (clr) begin
                        for (int i = 0; i < NUM_OPS; i++) begin
                            r_op[i] <= '0;
                        end
                    end else begin
                        for (int i = 0; i < NUM_OPS; i++) begin
                            if (w_load_rise[i]) r_op[i] <= din;
                        end
                    end
                    if (w_start_rise) begin
                        r_acc  <= '0;
                        r_flag <= 1'b0;
                        r_idx  <= '0;
                    end
                end
                ST_ACC: begin
                    r_acc  <= w_add[SUM_W-1:0];
                    r_flag <= w_flag_next;
                    r_idx  <= r_idx + c_idx_one;
                    if (w_last) begin
                        r_sum  <= w_add[SUM_W-1:0];
                        r_cout <= w_flag_next;
                    end
                end
                ST_DONE: begin
                    r_acc  <= '0;
                    r_flag <= 1'b0;
                    r_idx  <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = (r_state == ST_ACC);
    assign done = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_multi_operand_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_operand_adder
//  Brief    : Scoreboard bench for multi_operand_adder (WIDTH=4, NUM_OPS=5, SUM_W=6).
//  Revision : 1.0
// ============================================================================
module tb_multi_operand_adder;

    localparam int WIDTH   = 4;
    localparam int NUM_OPS = 5;
    localparam int SUM_W   = 6;
    localparam int LIM     = 40;

    logic               clk;
    logic               rst_n;
    logic [NUM_OPS-1:0] load;
    logic [WIDTH-1:0]   din;
    logic               start;
    logic               auto_i;
    logic               clr;
    logic [SUM_W-1:0]   sum;
    logic               cout;
    logic               busy;
    logic               done;

    int         n_vec;
    int         n_err;
    int         m_op [NUM_OPS];
    logic [6:0] sb_q [$];
    logic [6:0] mon_exp;
    int         lat;
    int         nbusy;

    multi_operand_adder #(
        .WIDTH  (WIDTH),
        .NUM_OPS(NUM_OPS),
        .SUM_W  (SUM_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .din   (din),
        .start (start),
        .auto_i(auto_i),
        .clr   (clr),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {cout, sum}: totals here never exceed 2*64, so one wrap at most.
    function automatic logic [6:0] expect_sum();
        int          t;
        logic [31:0] tv;
        t = 0;
        for (int i = 0; i < NUM_OPS; i++) t += m_op[i];
        tv = t;
        return {(t >= 64), tv[5:0]};
    endfunction

    task automatic push_expect();
        sb_q.push_back(expect_sum());
    endtask

    task automatic load_ch(input logic [NUM_OPS-1:0] mask, input logic [WIDTH-1:0] val);
        din  = val;
        load = mask;
        tick();
        load = '0;
        tick();
        for (int i = 0; i < NUM_OPS; i++) if (mask[i]) m_op[i] = int'(val);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int l, output int nb);
        l  = 0;
        nb = 0;
        do begin
            if (busy) nb++;
            tick();
            l++;
        end while (!done && l < LIM);
        if (!done) check("done_timeout", 0, 1);
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("sum", 32'(sum), 32'(mon_exp[5:0]));
                check("cout", 32'(cout), 32'(mon_exp[6]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        load   = '0;
        din    = '0;
        start  = 1'b0;
        auto_i = 1'b0;
        clr    = 1'b0;
        for (int i = 0; i < NUM_OPS; i++) m_op[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        rst_n = 1'b1;
        tick();

        // Operands 1..5 -> 15, no carry
        for (int i = 0; i < NUM_OPS; i++) load_ch(NUM_OPS'(1 << i), WIDTH'(i + 1));
        push_expect();
        start_pulse();
        run_to_done(lat, nbusy);
        check("latency", lat, 5);
        check("busy_cycles", nbusy, 5);
        check("done_busy_low", 32'(busy), 0);
        tick();
        check("done_width", 32'(done), 0);

        // Simultaneous load of 15 on all channels -> 75 mod 64 = 11, carry
        load_ch('1, 4'd15);
        push_expect();
        start_pulse();
        run_to_done(lat, nbusy);
        check("latency_all15", lat, 5);
        tick();

        // Load and start during ACC are ignored
        push_expect();
        start_pulse();
        tick();
        din   = 4'd9;
        load  = 5'b00100;
        start = 1'b1;
        tick();
        load  = '0;
        start = 1'b0;
        run_to_done(lat, nbusy);
        check("latency_frozen", lat, 3);
        tick();
        check("no_restart", 32'(busy), 0);
        tick();
        check("no_restart2", 32'(busy), 0);
        push_expect();
        start_pulse();
        run_to_done(lat, nbusy);
        tick();

        // Auto mode: 3*5 = 15 every 6 cycles
        load_ch('1, 4'd3);
        push_expect();
        push_expect();
        push_expect();
        auto_i = 1'b1;
        start_pulse();
        run_to_done(lat, nbusy);
        check("auto_first", lat, 5);
        run_to_done(lat, nbusy);
        check("auto_period", lat, 6);
        tick();
        check("auto_restart_busy", 32'(busy), 1);
        auto_i = 1'b0;
        run_to_done(lat, nbusy);
        check("auto_last", lat, 5);
        tick();
        check("auto_off_busy", 32'(busy), 0);
        check("auto_off_done", 32'(done), 0);
        repeat (8) tick();
        check("auto_off_idle", 32'(busy), 0);

        // Reset on the third ACC cycle
        for (int i = 0; i < NUM_OPS; i++) load_ch(NUM_OPS'(1 << i), WIDTH'(i + 1));
        push_expect();
        start_pulse();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum", 32'(sum), 0);
        check("mid_rst_cout", 32'(cout), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        sb_q.delete();
        for (int i = 0; i < NUM_OPS; i++) m_op[i] = 0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_idle", 32'(busy), 0);
        for (int i = 0; i < NUM_OPS; i++) load_ch(NUM_OPS'(1 << i), WIDTH'(i + 1));
        push_expect();
        start_pulse();
        run_to_done(lat, nbusy);
        check("post_rst_latency", lat, 5);
        tick();

        // clr beats a simultaneous load rise
        clr  = 1'b1;
        din  = 4'd7;
        load = 5'b00001;
        tick();
        clr  = 1'b0;
        load = '0;
        tick();
        for (int i = 0; i < NUM_OPS; i++) m_op[i] = 0;
        push_expect();
        start_pulse();
        run_to_done(lat, nbusy);
        check("clr_latency", lat, 5);
        repeat (3) tick();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
